// File: rtl/perf_pkg.sv
// ---------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the memory-mapped performance counter bank:
// register-window offsets, CTRL bit positions, the bus FSM state type and
// the byte-enable merge helper.
// ---------------------------------------------------------------------------
package perf_pkg;

    localparam int unsigned BUS_W    = 32;
    localparam int unsigned MASK_W   = BUS_W / 8;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned NUM_SLOT = 64;

    localparam logic [7:0] OFS_OVF  = 8'hF8;
    localparam logic [7:0] OFS_CTRL = 8'hFC;

    localparam int unsigned CTRL_FREEZE_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Replace the bytes of old_val selected by wmask with the bytes of wdata.
    function automatic logic [BUS_W-1:0] byte_merge(
        input logic [BUS_W-1:0]  old_val,
        input logic [BUS_W-1:0]  wdata,
        input logic [MASK_W-1:0] wmask
    );
        logic [BUS_W-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(MASK_W); b++) begin
            if (wmask[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// ---------------------------------------------------------------------------
// perf_counter
// One event counter with clear, software preload and overflow detection.
// Priority within a cycle: clear > load > increment.
// Build option: PERF_SATURATE_EN makes the counter stick at all-ones
// instead of wrapping; the overflow pulse still fires on that event.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   inc_i           increment request (already gated by freeze)
//   load_i          software write strobe
//   load_data_i     value to load
//   clear_i         synchronous clear
//   count_o         current count (registered)
//   ovf_pulse_o     combinational: this cycle's increment overflows
// ---------------------------------------------------------------------------
module perf_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_data_i,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 ovf_pulse_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next-count selection and overflow detection.
    always_comb begin
        count_d     = count_q;
        ovf_pulse_o = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_data_i;
        end else if (inc_i) begin
            if (count_q == {CNT_WIDTH{1'b1}}) begin
                ovf_pulse_o = 1'b1;
`ifdef PERF_SATURATE_EN
                count_d = count_q;
`else
                count_d = '0;
`endif
            end else begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/perf_counter_mmio.sv
// ---------------------------------------------------------------------------
// perf_counter_mmio
// Bank of NUM_EVENTS event counters mapped into a 256-byte window of the
// CPU data-memory path. Window hits are answered locally after one wait
// cycle; everything else passes straight through to the cache.
// Window map: counter i at +4*i, OVF (sticky, write-1-to-clear) at +0xF8,
// CTRL at +0xFC (bit0 FREEZE r/w, bit1 CLEAR write-only, reads 0).
// Build option: PERF_SATURATE_EN (saturating counters, see perf_counter).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   event_i             per-counter one-cycle event pulses
//   cpu_dmem_*          CPU-side request / response
//   cache_dmem_*        cache-side forwarded request / response
// ---------------------------------------------------------------------------
module perf_counter_mmio
    import perf_pkg::*;
#(
    parameter int unsigned      NUM_EVENTS = 8,
    parameter int unsigned      CNT_WIDTH  = 32,
    parameter logic [BUS_W-1:0] BASE_ADDR  = 32'hFFFF_FF00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [BUS_W-1:0]      cpu_dmem_addr,
    input  logic                  cpu_dmem_read,
    input  logic                  cpu_dmem_write,
    input  logic [BUS_W-1:0]      cpu_dmem_wdata,
    input  logic [MASK_W-1:0]     cpu_dmem_wmask,
    output logic [BUS_W-1:0]      cpu_dmem_rdata,
    output logic                  cpu_dmem_resp,
    output logic [BUS_W-1:0]      cache_dmem_addr,
    output logic                  cache_dmem_read,
    output logic                  cache_dmem_write,
    input  logic [BUS_W-1:0]      cache_dmem_rdata,
    input  logic                  cache_dmem_resp
);

    state_e                state_q, state_d;
    logic [BUS_W-1:0]      rdata_q, rdata_d;
    logic                  freeze_q, freeze_d;
    logic [NUM_EVENTS-1:0] ovf_q, ovf_d;

    logic                  hit_c, req_c, accept_c, wr_c;
    logic                  ctrl_wr_c, ovf_wr_c, cnt_wr_c, clear_c;
    logic [7:0]            ofs_c;
    logic [IDX_W-1:0]      idx_c;
    logic [BUS_W-1:0]      reg_rdata_c;
    logic [CNT_WIDTH-1:0]  load_data_c;
    logic [NUM_EVENTS-1:0] w1c_c;
    logic [NUM_EVENTS-1:0] ovf_pulse_c;

    logic [CNT_WIDTH-1:0]  count_w [NUM_EVENTS];
    logic [BUS_W-1:0]      cnt_rd  [NUM_SLOT];

    // Address decode and write strobes (writes commit on the IDLE->RESP edge).
    assign hit_c     = (cpu_dmem_addr[BUS_W-1:8] == BASE_ADDR[BUS_W-1:8]);
    assign req_c     = cpu_dmem_read | cpu_dmem_write;
    assign ofs_c     = cpu_dmem_addr[7:0];
    assign idx_c     = cpu_dmem_addr[7:2];
    assign accept_c  = (state_q == IDLE) && hit_c && req_c;
    assign wr_c      = accept_c && cpu_dmem_write;
    assign ctrl_wr_c = wr_c && (ofs_c == OFS_CTRL) && cpu_dmem_wmask[0];
    assign ovf_wr_c  = wr_c && (ofs_c == OFS_OVF);
    assign cnt_wr_c  = wr_c && (32'(idx_c) < NUM_EVENTS);
    assign clear_c   = ctrl_wr_c && cpu_dmem_wdata[CTRL_CLEAR_BIT];

    // Counter preload keeps unselected bytes; bits above CNT_WIDTH drop out.
    assign load_data_c = CNT_WIDTH'(byte_merge(cnt_rd[idx_c], cpu_dmem_wdata, cpu_dmem_wmask));
    assign w1c_c       = ovf_wr_c
                       ? NUM_EVENTS'(byte_merge('0, cpu_dmem_wdata, cpu_dmem_wmask))
                       : '0;

    // Counter instances; read slots past NUM_EVENTS return zero.
    for (genvar i = 0; i < int'(NUM_EVENTS); i++) begin : g_cnt
        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (event_i[i] & ~freeze_q),
            .load_i      (cnt_wr_c && (idx_c == IDX_W'(i))),
            .load_data_i (load_data_c),
            .clear_i     (clear_c),
            .count_o     (count_w[i]),
            .ovf_pulse_o (ovf_pulse_c[i])
        );
        assign cnt_rd[i] = 32'(count_w[i]);
    end

    for (genvar j = int'(NUM_EVENTS); j < int'(NUM_SLOT); j++) begin : g_pad
        assign cnt_rd[j] = '0;
    end

    // Register read mux.
    always_comb begin
        reg_rdata_c = cnt_rd[idx_c];
        if (ofs_c == OFS_OVF) begin
            reg_rdata_c = 32'(ovf_q);
        end else if (ofs_c == OFS_CTRL) begin
            reg_rdata_c = 32'(freeze_q);
        end
    end

    // Control / overflow next state; a new overflow beats a same-cycle W1C.
    always_comb begin
        freeze_d = freeze_q;
        ovf_d    = (ovf_q & ~w1c_c) | ovf_pulse_c;
        if (ctrl_wr_c) begin
            freeze_d = cpu_dmem_wdata[CTRL_FREEZE_BIT];
        end
        if (clear_c) begin
            ovf_d = '0;
        end
    end

    // Bus FSM next state: capture read data on acceptance, answer once.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (hit_c && req_c) begin
                    state_d = RESP;
                    rdata_d = reg_rdata_c;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            freeze_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            freeze_q <= freeze_d;
            ovf_q    <= ovf_d;
        end
    end

    // Cache-side pass-through; window hits never reach the cache.
    assign cache_dmem_addr  = cpu_dmem_addr;
    assign cache_dmem_read  = cpu_dmem_read  & ~hit_c;
    assign cache_dmem_write = cpu_dmem_write & ~hit_c;

    assign cpu_dmem_resp  = (state_q == RESP) | (~hit_c & cache_dmem_resp);
    assign cpu_dmem_rdata = (state_q == RESP) ? rdata_q : cache_dmem_rdata;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// ---------------------------------------------------------------------------
// tb_perf_counter_mmio
// Scoreboard bench for perf_counter_mmio (NUM_EVENTS=8, CNT_WIDTH=4).
// Stimulus pushes the expected read data for each bus access into a queue;
// an independent monitor pops and compares on every cpu_dmem_resp.
// Honours PERF_SATURATE_EN for the wrap/saturate expectations.
// ---------------------------------------------------------------------------
module tb_perf_counter_mmio;

    localparam int unsigned NE   = 8;
    localparam int unsigned CW   = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] CKEY = 32'hCAFE_0000;
`ifdef PERF_SATURATE_EN
    localparam logic [31:0] WRAP_VAL = 32'h0000_000F;
`else
    localparam logic [31:0] WRAP_VAL = 32'h0000_0000;
`endif

    logic          clk;
    logic          rst;
    logic [NE-1:0] event_i;
    logic [31:0]   cpu_dmem_addr;
    logic          cpu_dmem_read;
    logic          cpu_dmem_write;
    logic [31:0]   cpu_dmem_wdata;
    logic [3:0]    cpu_dmem_wmask;
    logic [31:0]   cpu_dmem_rdata;
    logic          cpu_dmem_resp;
    logic [31:0]   cache_dmem_addr;
    logic          cache_dmem_read;
    logic          cache_dmem_write;
    logic [31:0]   cache_dmem_rdata;
    logic          cache_dmem_resp;

    typedef struct {
        logic [31:0] data;
        logic        chk;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    perf_counter_mmio #(
        .NUM_EVENTS (NE),
        .CNT_WIDTH  (CW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .event_i          (event_i),
        .cpu_dmem_addr    (cpu_dmem_addr),
        .cpu_dmem_read    (cpu_dmem_read),
        .cpu_dmem_write   (cpu_dmem_write),
        .cpu_dmem_wdata   (cpu_dmem_wdata),
        .cpu_dmem_wmask   (cpu_dmem_wmask),
        .cpu_dmem_rdata   (cpu_dmem_rdata),
        .cpu_dmem_resp    (cpu_dmem_resp),
        .cache_dmem_addr  (cache_dmem_addr),
        .cache_dmem_read  (cache_dmem_read),
        .cache_dmem_write (cache_dmem_write),
        .cache_dmem_rdata (cache_dmem_rdata),
        .cache_dmem_resp  (cache_dmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency cache model: data is a fixed function of the address.
    assign cache_dmem_rdata = cache_dmem_addr ^ CKEY;
    assign cache_dmem_resp  = cache_dmem_read | cache_dmem_write;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && cpu_dmem_resp === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got rdata 0x%08h expected no response", cpu_dmem_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) begin
                    check(e.name, cpu_dmem_rdata, e.data);
                end
            end
        end
    end

    task automatic pulse(input logic [NE-1:0] mask, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            event_i = mask;
        end
        @(posedge clk); #1;
        event_i = '0;
    endtask

    // One bus access; ev is applied only in the request cycle.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [NE-1:0] ev,
                          input logic chk, input logic [31:0] exp, input string name);
        int  k;
        logic hit;
        hit = (addr[31:8] == BASE[31:8]);
        @(posedge clk); #1;
        cpu_dmem_addr  = addr;
        cpu_dmem_read  = ~wr;
        cpu_dmem_write = wr;
        cpu_dmem_wdata = wdata;
        cpu_dmem_wmask = wmask;
        event_i        = ev;
        sb.push_back('{exp, chk, name});
        @(negedge clk);
        if (hit) begin
            check({name, "_cache_rw"}, 32'({cache_dmem_read, cache_dmem_write}), 32'h0);
        end else begin
            check({name, "_cache_rw"}, 32'({cache_dmem_read, cache_dmem_write}), wr ? 32'h1 : 32'h2);
            check({name, "_cache_addr"}, cache_dmem_addr, addr);
        end
        k = 0;
        while (cpu_dmem_resp !== 1'b1 && k < 4) begin
            @(posedge clk); #1;
            event_i = '0;
            @(negedge clk);
            k++;
        end
        if (cpu_dmem_resp !== 1'b1) begin
            n_checks++;
            $display("FAIL %s_timeout: got no response expected resp within 4 cycles", name);
            void'(sb.pop_back());
        end
        @(posedge clk); #1;
        cpu_dmem_read  = 1'b0;
        cpu_dmem_write = 1'b0;
        event_i        = '0;
        @(negedge clk);
        check({name, "_resp_1cyc"}, 32'(cpu_dmem_resp), 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        access(1'b0, addr, 32'h0, 4'h0, '0, 1'b1, exp, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                      input string name);
        access(1'b1, addr, data, mask, '0, 1'b0, 32'h0, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        event_i        = '0;
        cpu_dmem_addr  = 32'h0;
        cpu_dmem_read  = 1'b0;
        cpu_dmem_write = 1'b0;
        cpu_dmem_wdata = 32'h0;
        cpu_dmem_wmask = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp", 32'(cpu_dmem_resp), 32'h0);
        check("rst_rdata_passthru", cpu_dmem_rdata, CKEY);
        @(posedge clk); #1;
        rst = 1'b0;

        // Counting and a basic window read.
        pulse(8'h08, 5);
        rd(BASE + 32'h0C, 32'd5, "t1_cnt3");
        rd(BASE + 32'h00, 32'd0, "t1_cnt0");

        // Pass-through to the cache.
        rd(32'h0000_1000, 32'hCAFE_1000, "t2_miss_rd");
        wr(32'h0000_2000, 32'h1234_5678, 4'hF, "t2_miss_wr");

        // Freeze / unfreeze.
        wr(BASE + 32'hFC, 32'h1, 4'hF, "t3_freeze");
        rd(BASE + 32'hFC, 32'h1, "t3_ctrl_rd");
        pulse(8'hFF, 10);
        rd(BASE + 32'h0C, 32'd5, "t3_cnt3_frozen");
        rd(BASE + 32'h00, 32'd0, "t3_cnt0_frozen");
        wr(BASE + 32'hFC, 32'h0, 4'hF, "t3_unfreeze");
        pulse(8'h08, 2);
        rd(BASE + 32'h0C, 32'd7, "t3_cnt3_resumed");

        // Byte enables, width truncation, unmapped offsets.
        wr(BASE + 32'h04, 32'hFFFF_FFF3, 4'h1, "bm_wr1");
        rd(BASE + 32'h04, 32'd3, "bm_cnt1");
        wr(BASE + 32'h04, 32'h0000_0000, 4'hE, "bm_wr2");
        rd(BASE + 32'h04, 32'd3, "bm_cnt1_kept");
        wr(BASE + 32'h80, 32'hFFFF_FFFF, 4'hF, "um_wr");
        rd(BASE + 32'h80, 32'd0, "um_rd");

        // Wrap (or saturate) and sticky overflow with W1C.
        wr(BASE + 32'h00, 32'h0000_000F, 4'hF, "t4_preload");
        rd(BASE + 32'h00, 32'hF, "t4_cnt0_pre");
        rd(BASE + 32'hF8, 32'h0, "t4_ovf_pre");
        pulse(8'h01, 1);
        rd(BASE + 32'h00, WRAP_VAL, "t4_cnt0_wrap");
        rd(BASE + 32'hF8, 32'h1, "t4_ovf_set");
        wr(BASE + 32'hF8, 32'h1, 4'hF, "t4_ovf_w1c");
        rd(BASE + 32'hF8, 32'h0, "t4_ovf_clr");

        // CLEAR beats a same-cycle increment; freeze bit is separate.
        wr(BASE + 32'h00, 32'h0000_000E, 4'hF, "t5_preload");
        pulse(8'h01, 2);
        rd(BASE + 32'hF8, 32'h1, "t5_ovf_set");
        access(1'b1, BASE + 32'hFC, 32'h2, 4'hF, 8'h01, 1'b0, 32'h0, "t5_clear");
        rd(BASE + 32'h00, 32'd0, "t5_cnt0");
        rd(BASE + 32'h0C, 32'd0, "t5_cnt3");
        rd(BASE + 32'hF8, 32'h0, "t5_ovf");
        rd(BASE + 32'hFC, 32'h0, "t5_ctrl");
        wr(BASE + 32'hFC, 32'h3, 4'hF, "t5_clear_freeze");
        rd(BASE + 32'hFC, 32'h1, "t5_ctrl_freeze");
        wr(BASE + 32'hFC, 32'h0, 4'hF, "t5_unfreeze");

        // Reset in the middle of a hit transaction.
        pulse(8'h08, 3);
        rd(BASE + 32'h0C, 32'd3, "t6_cnt3_pre");
        @(posedge clk); #1;
        cpu_dmem_addr = BASE + 32'h0C;
        cpu_dmem_read = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_resp", 32'(cpu_dmem_resp), 32'h0);
        check("t6_rst_rdata", cpu_dmem_rdata, 32'h3501_FF0C);
        @(posedge clk); #1;
        rst           = 1'b0;
        cpu_dmem_read = 1'b0;
        rd(BASE + 32'h0C, 32'd0, "t6_cnt3_post");
        rd(BASE + 32'hFC, 32'h0, "t6_ctrl_post");
        rd(BASE + 32'h04, 32'd0, "t6_cnt1_post");

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
